// File: rtl/alu_exec_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_unit_pkg
//   Shared definitions for the EX-stage execute unit and the ALU control
//   decoder that feeds it:
//     - 4-bit ALU control op codes (ALU_*)
//     - FSM state encoding of the execute unit
//     - shift direction encoding used by the iterative shifter
//     - default datapath width
//     - is_shift_op(): true for the op codes routed to the iterative shifter
// -----------------------------------------------------------------------------
package alu_exec_unit_pkg;

  localparam int XLEN_DEFAULT = 64;

  // Op codes produced by the ALU control decoder.
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  // Execute unit control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  typedef enum logic {
    SH_LEFT  = 1'b0,
    SH_RIGHT = 1'b1
  } shift_dir_e;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// -----------------------------------------------------------------------------
// alu_exec_unit_if
//   Handshake bundle between the pipeline and the execute unit.
//     Request side : in_valid, in_ready, alu_control, op_a, op_b
//     Response side: out_valid, out_ready, result, zero, busy
//   master modport: the pipeline stage issuing ops and consuming results.
//   slave  modport: the execute unit itself.
// -----------------------------------------------------------------------------
interface alu_exec_unit_if
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, alu_control, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_control, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );

endinterface

// File: rtl/alu_iter_shifter.sv
// -----------------------------------------------------------------------------
// alu_iter_shifter
//   Iterative shifter: moves the working value by at most SHIFT_STEP bit
//   positions per enabled cycle until the remaining count is exhausted.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset (clears all state)
//     load         : capture din / shamt / direction / fill bit
//     step_en      : perform one step this cycle
//     dir, arith   : shift direction; arith selects sign fill for right shifts
//     din, shamt   : shift source and amount (0..63)
//     value_next   : working value after the current step (valid with done)
//     done         : step_en and this step consumes the last remaining bits
// -----------------------------------------------------------------------------
module alu_iter_shifter
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step_en,
  input  shift_dir_e      dir,
  input  logic            arith,
  input  logic [XLEN-1:0] din,
  input  logic [5:0]      shamt,
  output logic [XLEN-1:0] value_next,
  output logic            done
);

  // Number of binary stages needed to shift by any amount 0..SHIFT_STEP.
  localparam int SW = $clog2(SHIFT_STEP) + 1;

  logic [XLEN-1:0] work_q, work_d;
  logic [5:0]      rem_q, rem_d;
  logic            fill_q, fill_d;
  shift_dir_e      dir_q, dir_d;
  logic [SW-1:0]   step_amt;

  // min(remaining, SHIFT_STEP); the short final step only happens when
  // remaining < SHIFT_STEP, so it fits in SW-1 bits.
  always_comb begin
    step_amt = SW'(SHIFT_STEP);
    if (rem_q < 6'(SHIFT_STEP)) begin
      step_amt = rem_q[SW-1:0];
    end
  end

  // Small log-stage shifter limited to SHIFT_STEP instead of a full barrel.
  for (genvar gi = 0; gi < SW; gi++) begin : g_stage
    localparam int K = 1 << gi;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] out;

    if (gi == 0) begin : g_first
      assign src = work_q;
    end else begin : g_rest
      assign src = g_stage[gi-1].out;
    end

    assign shifted = (dir_q == SH_LEFT) ? (src << K)
                                        : {{K{fill_q}}, src[XLEN-1:K]};
    assign out     = step_amt[gi] ? shifted : src;
  end

  assign value_next = g_stage[SW-1].out;
  assign done       = step_en && (rem_q <= 6'(SHIFT_STEP));

  always_comb begin
    work_d = work_q;
    rem_d  = rem_q;
    fill_d = fill_q;
    dir_d  = dir_q;
    if (load) begin
      work_d = din;
      rem_d  = shamt;
      // SRA fill comes from the original operand sign, captured once.
      fill_d = arith & din[XLEN-1];
      dir_d  = dir;
    end else if (step_en) begin
      work_d = value_next;
      rem_d  = rem_q - 6'(step_amt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q <= '0;
      rem_q  <= '0;
      fill_q <= 1'b0;
      dir_q  <= SH_LEFT;
    end else begin
      work_q <= work_d;
      rem_q  <= rem_d;
      fill_q <= fill_d;
      dir_q  <= dir_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   EX-stage execute unit. Single-cycle AND/OR/ADD/SUB/SLT/SLTU/XOR/NOP,
//   iterative SLL/SRL/SRA through alu_iter_shifter. Result and zero flag are
//   registered and held until the consumer takes them.
//   Ports:
//     clk    : clock, rising edge
//     reset  : synchronous, active-high
//     bus    : alu_exec_unit_if.slave
//              in_valid/in_ready/alu_control/op_a/op_b  request handshake
//              out_valid/out_ready/result/zero          response handshake
//              busy                                     shift in progress
//   Parameters:
//     XLEN       : operand/result width
//     SHIFT_STEP : max bits shifted per cycle (1, 2, 4, 8, 16 or 32)
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  alu_exec_unit_if.slave  bus
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            in_ready_q, in_ready_d;

  logic [XLEN-1:0] alu_out;
  logic            accept;
  logic            sh_load;
  logic            sh_step;
  logic            sh_done;
  logic [XLEN-1:0] sh_value;
  shift_dir_e      sh_dir;
  logic            sh_arith;

  assign accept = bus.in_valid && in_ready_q;

  // Single-cycle datapath; undefined codes fall through to 0 like NOP.
  always_comb begin
    alu_out = '0;
    unique case (bus.alu_control)
      ALU_AND:  alu_out = bus.op_a & bus.op_b;
      ALU_OR:   alu_out = bus.op_a | bus.op_b;
      ALU_ADD:  alu_out = bus.op_a + bus.op_b;
      ALU_SUB:  alu_out = bus.op_a - bus.op_b;
      ALU_SLT:  alu_out = XLEN'($signed(bus.op_a) < $signed(bus.op_b));
      ALU_XOR:  alu_out = bus.op_a ^ bus.op_b;
      ALU_SLTU: alu_out = XLEN'(bus.op_a < bus.op_b);
      default:  alu_out = '0;
    endcase
  end

  assign sh_dir   = (bus.alu_control == ALU_SLL) ? SH_LEFT : SH_RIGHT;
  assign sh_arith = (bus.alu_control == ALU_SRA);
  assign sh_step  = (state_q == SHIFT);

  alu_iter_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (sh_load),
    .step_en    (sh_step),
    .dir        (sh_dir),
    .arith      (sh_arith),
    .din        (bus.op_a),
    .shamt      (bus.op_b[5:0]),
    .value_next (sh_value),
    .done       (sh_done)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    sh_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift_op(bus.alu_control)) begin
            sh_load = 1'b1;
            if (bus.op_b[5:0] == 6'd0) begin
              result_d = bus.op_a;
              state_d  = DONE;
            end else begin
              state_d  = SHIFT;
            end
          end else begin
            result_d = alu_out;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        if (sh_done) begin
          result_d = sh_value;
          state_d  = DONE;
        end
      end
      DONE: begin
        // No bypass: the freed slot is only offered from the next cycle on.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake outputs are registered decodes of the next state.
    zero_d      = (result_d == '0);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == SHIFT);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//   Drives two execute units (SHIFT_STEP=1 and SHIFT_STEP=8) with the same
//   stimulus and checks results, zero flag, latency and busy cycles against
//   hand-computed vectors, plus backpressure and mid-shift reset sequences.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  ctl;
  logic [63:0] a;
  logic [63:0] b;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(64)) bus1 ();
  alu_exec_unit_if #(.XLEN(64)) bus8 ();

  assign bus1.in_valid    = in_valid;
  assign bus1.alu_control = ctl;
  assign bus1.op_a        = a;
  assign bus1.op_b        = b;
  assign bus1.out_ready   = out_ready;
  assign bus8.in_valid    = in_valid;
  assign bus8.alu_control = ctl;
  assign bus8.op_a        = a;
  assign bus8.op_b        = b;
  assign bus8.out_ready   = out_ready;

  alu_exec_unit #(.XLEN(64), .SHIFT_STEP(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  alu_exec_unit #(.XLEN(64), .SHIFT_STEP(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  typedef struct {
    logic [3:0]  ctl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        z;
    int          lat1;
    int          lat8;
    int          busy1;
    int          busy8;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ov1_after"}, 64'(bus1.out_valid), 64'd0);
    chk({tag, "_ov8_after"}, 64'(bus8.out_valid), 64'd0);
    chk({tag, "_ir1_after"}, 64'(bus1.in_ready), 64'd1);
    chk({tag, "_ir8_after"}, 64'(bus8.in_ready), 64'd1);
  endtask

  task automatic do_op(input int idx, input vec_t v);
    int lat1, lat8, bz1, bz8;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    ctl = v.ctl; a = v.a; b = v.b; in_valid = 1'b1;
    chk({tag, "_ir1"}, 64'(bus1.in_ready), 64'd1);
    chk({tag, "_ir8"}, 64'(bus8.in_ready), 64'd1);
    @(posedge clk);
    // Scramble inputs after accept; they must not affect an op in flight.
    #1 in_valid = 1'b0; a = 64'h0123_4567_89AB_CDEF; b = 64'h3F; ctl = ALU_SRA;
    lat1 = 0; lat8 = 0; bz1 = 0; bz8 = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (lat1 == 0) begin
        if (bus1.out_valid) lat1 = cyc;
        else if (bus1.busy) bz1++;
      end
      if (lat8 == 0) begin
        if (bus8.out_valid) lat8 = cyc;
        else if (bus8.busy) bz8++;
      end
      if (lat1 != 0 && lat8 != 0) break;
    end
    $display("vec %0d ctl=%b a=%h b=%h -> r1=%h z1=%0b lat1=%0d | r8=%h z8=%0b lat8=%0d",
             idx, v.ctl, v.a, v.b, bus1.result, bus1.zero, lat1,
             bus8.result, bus8.zero, lat8);
    chk({tag, "_res1"},  bus1.result, v.res);
    chk({tag, "_zero1"}, 64'(bus1.zero), 64'(v.z));
    chk({tag, "_lat1"},  64'(lat1), 64'(v.lat1));
    chk({tag, "_busy1"}, 64'(bz1), 64'(v.busy1));
    chk({tag, "_res8"},  bus8.result, v.res);
    chk({tag, "_zero8"}, 64'(bus8.zero), 64'(v.z));
    chk({tag, "_lat8"},  64'(lat8), 64'(v.lat8));
    chk({tag, "_busy8"}, 64'(bz8), 64'(v.busy8));
    release_result(tag);
  endtask

  initial begin
    vecs[0]  = '{ALU_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1, 1, 0, 0};
    vecs[1]  = '{ALU_SUB,  64'd5, 64'd5, 64'd0, 1'b1, 1, 1, 0, 0};
    vecs[2]  = '{ALU_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1, 1, 0, 0};
    vecs[3]  = '{ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1, 1, 0, 0};
    vecs[4]  = '{4'b0101,  64'd3, 64'd4, 64'd0, 1'b1, 1, 1, 0, 0};
    vecs[5]  = '{ALU_AND,  64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1, 1, 0, 0};
    vecs[6]  = '{ALU_OR,   64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0, 1, 1, 0, 0};
    vecs[7]  = '{ALU_XOR,  64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, 1, 1, 0, 0};
    vecs[8]  = '{ALU_NOP,  64'd7, 64'd9, 64'd0, 1'b1, 1, 1, 0, 0};
    vecs[9]  = '{ALU_SUB,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 1, 0, 0};
    vecs[10] = '{ALU_SRA,  64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64, 9, 63, 8};
    vecs[11] = '{ALU_SRL,  64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 64, 9, 63, 8};
    vecs[12] = '{ALU_SLL,  64'hDEAD, 64'h40, 64'hDEAD, 1'b0, 1, 1, 0, 0};
    vecs[13] = '{ALU_SLL,  64'd1, 64'd4, 64'h10, 1'b0, 5, 2, 4, 1};
    vecs[14] = '{ALU_SRA,  64'hF000_0000_0000_0000, 64'd12, 64'hFFFF_0000_0000_0000, 1'b0, 13, 3, 12, 2};
    vecs[15] = '{ALU_SRA,  64'h4000_0000_0000_0000, 64'd62, 64'd1, 1'b0, 63, 9, 62, 8};
    vecs[16] = '{ALU_SRL,  64'h100, 64'd4, 64'h10, 1'b0, 5, 2, 4, 1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ctl = ALU_NOP; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    $display("reset: ir1=%0b ov1=%0b busy1=%0b r1=%h z1=%0b",
             bus1.in_ready, bus1.out_valid, bus1.busy, bus1.result, bus1.zero);
    chk("rst_in_ready",  64'(bus1.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("rst_busy",      64'(bus1.busy), 64'd0);
    chk("rst_result",    bus1.result, 64'd0);
    chk("rst_zero",      64'(bus1.zero), 64'd1);
    chk("rst_result8",   bus8.result, 64'd0);

    for (int i = 0; i < NVEC - 1; i++) begin
      do_op(i, vecs[i]);
    end

    // Backpressure: result held, new request ignored until released.
    @(negedge clk);
    ctl = ALU_ADD; a = 64'd2; b = 64'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 ctl = ALU_SUB; a = 64'd9; b = 64'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      $display("bp cycle %0d: r1=%h ov1=%0b ir1=%0b r8=%h", i, bus1.result,
               bus1.out_valid, bus1.in_ready, bus8.result);
      chk($sformatf("bp_res1_%0d", i), bus1.result, 64'd5);
      chk($sformatf("bp_ov1_%0d", i),  64'(bus1.out_valid), 64'd1);
      chk($sformatf("bp_ir1_%0d", i),  64'(bus1.in_ready), 64'd0);
      chk($sformatf("bp_res8_%0d", i), bus8.result, 64'd5);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    $display("bp release: ir1=%0b ov1=%0b r1=%h", bus1.in_ready, bus1.out_valid, bus1.result);
    chk("bp_rel_ir1",  64'(bus1.in_ready), 64'd1);
    chk("bp_rel_ov1",  64'(bus1.out_valid), 64'd0);
    chk("bp_rel_res1", bus1.result, 64'd5);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    $display("bp new op: ov1=%0b r1=%h r8=%h", bus1.out_valid, bus1.result, bus8.result);
    chk("bp_new_ov1",  64'(bus1.out_valid), 64'd1);
    chk("bp_new_res1", bus1.result, 64'd8);
    chk("bp_new_res8", bus8.result, 64'd8);
    release_result("bp");

    // Reset in the middle of SLL by 40.
    @(negedge clk);
    ctl = ALU_SLL; a = 64'd3; b = 64'd40; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mr_busy1_pre", 64'(bus1.busy), 64'd1);
    chk("mr_ov8_pre",   64'(bus8.out_valid), 64'd1);
    chk("mr_res8_pre",  bus8.result, 64'd3 << 40);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    $display("midreset: ov1=%0b busy1=%0b r1=%h z1=%0b ir1=%0b ov8=%0b r8=%h",
             bus1.out_valid, bus1.busy, bus1.result, bus1.zero, bus1.in_ready,
             bus8.out_valid, bus8.result);
    chk("mr_ov1",   64'(bus1.out_valid), 64'd0);
    chk("mr_busy1", 64'(bus1.busy), 64'd0);
    chk("mr_res1",  bus1.result, 64'd0);
    chk("mr_zero1", 64'(bus1.zero), 64'd1);
    chk("mr_ir1",   64'(bus1.in_ready), 64'd1);
    chk("mr_ov8",   64'(bus8.out_valid), 64'd0);
    chk("mr_res8",  bus8.result, 64'd0);
    chk("mr_ir8",   64'(bus8.in_ready), 64'd1);
    do_op(NVEC - 1, vecs[NVEC - 1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
